// File: rtl/uart_fifo_if.sv
// Request/response bundle between the core controller and the buffered UART unit.
// Handshake: uart_go is a one-cycle request strobe. rors and txdata are only looked at
// in that cycle. uart_done is a one-cycle completion pulse. rxdata holds the byte from
// the last completed read until the next read completes.
interface uart_fifo_if;
  logic       uart_go;
  logic       rors;
  logic [7:0] txdata;
  logic       uart_done;
  logic [7:0] rxdata;
  logic       rx_overrun;

  modport master (
    output uart_go, rors, txdata,
    input  uart_done, rxdata, rx_overrun
  );

  modport slave (
    input  uart_go, rors, txdata,
    output uart_done, rxdata, rx_overrun
  );
endinterface

// File: rtl/uart_fifo_unit.sv
// Buffered UART responder: RX FIFO filled by a deserializer on rxd and TX FIFO drained
// by a serializer on txd, both serving the controller's go/done request handshake.
module uart_fifo_unit #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int DEPTH            = 16
) (
  input  logic        clk,
  input  logic        rst,
  uart_fifo_if.slave  bus,
  output logic        txd,
  input  logic        rxd,
  output logic [4:0]  dbg_state
);

  localparam int BP = 2 * CLK_PER_HALF_BIT;
  localparam int CW = $clog2(BP);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] BP_LAST   = CW'(BP - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_PER_HALF_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic {REQ_IDLE, REQ_WAIT} req_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  req_state_t req_state;
  rx_state_t  rx_state;
  tx_state_t  tx_state;

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rxf_wp, rxf_rp;
  logic [AW:0]   rxf_cnt;
  logic          rxf_empty, rxf_full, rxf_push, rxf_pop;
  logic [7:0]    rx_shift;

  assign rxf_empty = (rxf_cnt == '0);
  assign rxf_full  = (rxf_cnt == CNT_FULL);

  always_ff @(posedge clk) begin
    if (rxf_push) rx_mem[rxf_wp] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rxf_wp  <= '0;
      rxf_rp  <= '0;
      rxf_cnt <= '0;
    end else begin
      if (rxf_push) rxf_wp <= rxf_wp + PTR_ONE;
      if (rxf_pop)  rxf_rp <= rxf_rp + PTR_ONE;
      case ({rxf_push, rxf_pop})
        2'b10:   rxf_cnt <= rxf_cnt + CNT_ONE;
        2'b01:   rxf_cnt <= rxf_cnt - CNT_ONE;
        default: rxf_cnt <= rxf_cnt;
      endcase
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] txf_wp, txf_rp;
  logic [AW:0]   txf_cnt;
  logic          txf_empty, txf_full, txf_push, txf_pop;
  logic [7:0]    txf_din;

  assign txf_empty = (txf_cnt == '0);
  assign txf_full  = (txf_cnt == CNT_FULL);

  always_ff @(posedge clk) begin
    if (txf_push) tx_mem[txf_wp] <= txf_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txf_wp  <= '0;
      txf_rp  <= '0;
      txf_cnt <= '0;
    end else begin
      if (txf_push) txf_wp <= txf_wp + PTR_ONE;
      if (txf_pop)  txf_rp <= txf_rp + PTR_ONE;
      case ({txf_push, txf_pop})
        2'b10:   txf_cnt <= txf_cnt + CNT_ONE;
        2'b01:   txf_cnt <= txf_cnt - CNT_ONE;
        default: txf_cnt <= txf_cnt;
      endcase
    end
  end

  // ---------------- Request FSM ----------------
  logic       kind_q;
  logic [7:0] data_q;
  logic       cur_kind, req_active, rd_fire, wr_fire;
  logic       done_r;
  logic [7:0] rxdata_r;

  // In REQ_IDLE the request is served straight from the inputs so a ready FIFO
  // completes in the uart_go cycle itself; afterwards the latched copy is used.
  assign cur_kind   = (req_state == REQ_IDLE) ? bus.rors    : kind_q;
  assign txf_din    = (req_state == REQ_IDLE) ? bus.txdata  : data_q;
  assign req_active = (req_state == REQ_IDLE) ? bus.uart_go : 1'b1;
  assign rd_fire    = req_active && !cur_kind && !rxf_empty;
  assign wr_fire    = req_active &&  cur_kind && !txf_full;
  assign rxf_pop    = rd_fire;
  assign txf_push   = wr_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_state <= REQ_IDLE;
      kind_q    <= 1'b0;
      data_q    <= '0;
      done_r    <= 1'b0;
      rxdata_r  <= '0;
    end else begin
      done_r <= rd_fire || wr_fire;
      if (rd_fire) rxdata_r <= rx_mem[rxf_rp];
      case (req_state)
        REQ_IDLE: begin
          if (bus.uart_go) begin
            kind_q <= bus.rors;
            data_q <= bus.txdata;
            if (!(rd_fire || wr_fire)) req_state <= REQ_WAIT;
          end
        end
        REQ_WAIT: begin
          if (rd_fire || wr_fire) req_state <= REQ_IDLE;
        end
        default: req_state <= REQ_IDLE;
      endcase
    end
  end

  assign bus.uart_done = done_r;
  assign bus.rxdata    = rxdata_r;

  // ---------------- RX deserializer ----------------
  logic          rx_s1, rx_s2, rx_s3, rx_fall;
  logic [CW-1:0] rx_baud;
  logic [3:0]    rx_bit;
  logic          overrun_r;

  assign rx_fall  = rx_s3 && !rx_s2;
  assign rxf_push = (rx_state == RX_STOP) && (rx_baud == BP_LAST) && rx_s2 && !rxf_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_baud   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      overrun_r <= 1'b0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          if (rx_fall) begin
            rx_state <= RX_START;
            rx_baud  <= '0;
          end
        end
        RX_START: begin
          // Half a bit in: a line back high means the falling edge was a glitch.
          if (rx_baud == HALF_LAST) begin
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud <= rx_baud + BAUD_ONE;
          end
        end
        RX_DATA: begin
          if (rx_baud == BP_LAST) begin
            rx_baud  <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 4'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 4'd1;
          end else begin
            rx_baud <= rx_baud + BAUD_ONE;
          end
        end
        RX_STOP: begin
          if (rx_baud == BP_LAST) begin
            rx_baud  <= '0;
            rx_state <= RX_IDLE;
            if (!rx_s2 || rxf_full) overrun_r <= 1'b1;
          end else begin
            rx_baud <= rx_baud + BAUD_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  assign bus.rx_overrun = overrun_r;

  // ---------------- TX serializer ----------------
  logic [CW-1:0] tx_baud;
  logic [3:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          txd_r;
  logic          tx_load;

  // A new frame is loaded from idle or straight out of a finished stop bit.
  assign tx_load = !txf_empty &&
                   ((tx_state == TX_IDLE) ||
                    ((tx_state == TX_STOP) && (tx_baud == BP_LAST)));
  assign txf_pop = tx_load;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txd_r    <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          txd_r <= 1'b1;
          if (tx_load) begin
            tx_shift <= tx_mem[txf_rp];
            tx_baud  <= '0;
            tx_state <= TX_START;
            txd_r    <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_baud == BP_LAST) begin
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
            txd_r    <= tx_shift[0];
          end else begin
            tx_baud <= tx_baud + BAUD_ONE;
          end
        end
        TX_DATA: begin
          if (tx_baud == BP_LAST) begin
            tx_baud <= '0;
            if (tx_bit == 4'd7) begin
              tx_state <= TX_STOP;
              txd_r    <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 4'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              txd_r    <= tx_shift[1];
            end
          end else begin
            tx_baud <= tx_baud + BAUD_ONE;
          end
        end
        TX_STOP: begin
          if (tx_baud == BP_LAST) begin
            tx_baud <= '0;
            if (tx_load) begin
              tx_shift <= tx_mem[txf_rp];
              tx_state <= TX_START;
              txd_r    <= 1'b0;
            end else begin
              tx_state <= TX_IDLE;
            end
          end else begin
            tx_baud <= tx_baud + BAUD_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  assign txd       = txd_r;
  assign dbg_state = {req_state, rx_state, tx_state};

endmodule

// File: tb/tb_uart_fifo_unit.sv
// Scoreboard bench for uart_fifo_unit: directed requests and rxd frames, with monitors
// checking uart_done/rxdata and every txd frame against expected queues.
module tb_uart_fifo_unit;
  localparam int HALF  = 4;
  localparam int BP    = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       txd;
  logic [4:0] dbg_state;

  uart_fifo_if bus();

  uart_fifo_unit #(.CLK_PER_HALF_BIT(HALF), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .txd       (txd),
    .rxd       (rxd),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];      // {is_read, expected rxdata} per uart_done
  logic [7:0] exp_tx_q[$];   // bytes expected on txd, in order
  int         tx_start_q[$];
  int         done_cnt = 0;
  int         last_done_cyc = 0;
  int         frame_fall_cyc = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- monitors ----------------
  logic [8:0] done_e;
  always @(negedge clk) begin
    if (!rst && bus.uart_done) begin
      done_cnt++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected actual pulse at cycle %0d required none", cyc);
      end else begin
        done_e = exp_q.pop_front();
        if (done_e[8]) check("rxdata", bus.rxdata, done_e[7:0]);
      end
    end
  end

  initial begin : tx_monitor
    logic [79:0] got, want;
    logic        aborted;
    logic [7:0]  b;
    forever begin
      @(negedge clk);
      if (!rst && txd == 1'b0) begin
        tx_start_q.push_back(cyc);
        got = '0;
        aborted = 1'b0;
        for (int c = 0; c < 80; c++) begin
          if (c > 0) @(negedge clk);
          if (rst) aborted = 1'b1;
          got[c] = txd;
        end
        if (!aborted) begin
          if (exp_tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_unexpected_frame actual %0h required none", got);
          end else begin
            b = exp_tx_q.pop_front();
            for (int c = 0; c < 80; c++)
              want[c] = (c < 8) ? 1'b0 : (c < 72) ? b[(c - 8) / 8] : 1'b1;
            check("tx_frame", got, want);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic req(input logic kind, input logic [7:0] d, input int limit, output int lat);
    int n;
    if (kind) begin
      exp_q.push_back({1'b0, 8'h00});
      exp_tx_q.push_back(d);
    end else begin
      exp_q.push_back({1'b1, d});
    end
    bus.uart_go = 1'b1;
    bus.rors    = kind;
    bus.txdata  = kind ? d : 8'h00;
    @(posedge clk);
    #1;
    bus.uart_go = 1'b0;
    n = 0;
    while (!bus.uart_done && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.uart_done) begin
      checks++;
      errors++;
      $display("FAIL req_timeout actual no uart_done required uart_done within %0d", limit);
    end
    lat = n + 1;
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    frame_fall_cyc = cyc;
    rxd = 1'b0;
    wait_cyc(BP);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(BP);
    end
    rxd = stop_bit;
    wait_cyc(BP);
    rxd = 1'b1;
  endtask

  task automatic wait_tx_drain(input string name);
    int n = 0;
    while (exp_tx_q.size() != 0 && n < 1000) begin
      wait_cyc(1);
      n++;
    end
    check(name, exp_tx_q.size(), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual still running required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int lat, t, d0;
    int lats[6];
    logic [7:0] tx6[6];
    logic [7:0] rx5[5];
    tx6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hF0};
    rx5 = '{8'h01, 8'h80, 8'hC5, 8'h7E, 8'h99};

    bus.uart_go = 1'b0;
    bus.rors    = 1'b0;
    bus.txdata  = 8'h00;
    rst = 1'b1;
    wait_cyc(3);
    check("rst_txd", txd, 1);
    check("rst_done", bus.uart_done, 0);
    check("rst_rxdata", bus.rxdata, 0);
    check("rst_overrun", bus.rx_overrun, 0);
    rst = 1'b0;
    wait_cyc(3);

    // send 0x55 from idle
    tx_start_q.delete();
    t = cyc;
    req(1'b1, 8'h55, TMO, lat);
    check("t1_send_lat", lat, 1);
    wait_tx_drain("t1_tx_drain");
    wait_cyc(20);
    check("t1_txd_idle", txd, 1);
    check("t1_frames", tx_start_q.size(), 1);
    if (tx_start_q.size() > 0) check("t1_start_cycle", tx_start_q[0], t + 2);

    // receive 0xA3, then read it
    drive_frame(8'hA3, 1'b1);
    wait_cyc(5);
    req(1'b0, 8'hA3, TMO, lat);
    check("t2_read_lat", lat, 1);
    wait_cyc(5);

    // blocking read satisfied by a frame arriving 200 cycles later
    d0 = done_cnt;
    fork
      req(1'b0, 8'h3C, 2000, lat);
      begin
        wait_cyc(200);
        check("t3_no_early_done", done_cnt, d0);
        drive_frame(8'h3C, 1'b1);
      end
    join
    wait_cyc(5);
    check("t3_done_once", done_cnt, d0 + 1);
    check("t3_done_cycle", last_done_cyc, frame_fall_cyc + 80);

    // six back-to-back sends into a 4-deep TX FIFO
    tx_start_q.delete();
    for (int i = 0; i < 6; i++) begin
      req(1'b1, tx6[i], TMO, lat);
      lats[i] = lat;
    end
    for (int i = 0; i < 4; i++) check("t4_send_lat", lats[i], 1);
    check("t4_sixth_waits_for_pop", lats[5], 78);
    wait_tx_drain("t4_tx_drain");
    check("t4_frames", tx_start_q.size(), 6);
    for (int i = 1; i < tx_start_q.size(); i++)
      check("t4_contiguous", tx_start_q[i] - tx_start_q[i-1], 80);
    wait_cyc(10);

    // five frames with no reads: fifth overruns, first four read back in order
    for (int i = 0; i < 5; i++) begin
      drive_frame(rx5[i], 1'b1);
      if (i == 3) check("t5_no_overrun_yet", bus.rx_overrun, 0);
    end
    wait_cyc(2);
    check("t5_overrun", bus.rx_overrun, 1);
    for (int i = 0; i < 4; i++) begin
      req(1'b0, rx5[i], TMO, lat);
      check("t5_read_lat", lat, 1);
    end
    wait_cyc(3);

    // framing error drops the byte
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(2);
    check("t5_overrun_cleared", bus.rx_overrun, 0);
    drive_frame(8'h96, 1'b0);
    wait_cyc(2);
    check("t5_framing_overrun", bus.rx_overrun, 1);
    drive_frame(8'h5A, 1'b1);
    wait_cyc(3);
    req(1'b0, 8'h5A, TMO, lat);
    check("t5_after_drop_lat", lat, 1);
    wait_cyc(3);

    // reset in the middle of a TX frame and an RX frame
    req(1'b1, 8'hC3, TMO, lat);
    check("t6_send_lat", lat, 1);
    rxd = 1'b0;
    wait_cyc(30);
    rst = 1'b1;
    rxd = 1'b1;
    wait_cyc(1);
    check("t6_rst_txd", txd, 1);
    check("t6_rst_done", bus.uart_done, 0);
    check("t6_rst_overrun", bus.rx_overrun, 0);
    rst = 1'b0;
    exp_tx_q.delete();
    t = tx_start_q.size();
    wait_cyc(5);
    rxd = 1'b0;
    wait_cyc(2);
    rxd = 1'b1;
    wait_cyc(60);
    d0 = done_cnt;
    bus.uart_go = 1'b1;
    bus.rors    = 1'b0;
    wait_cyc(1);
    bus.uart_go = 1'b0;
    wait_cyc(150);
    check("t6_rx_fifo_empty", done_cnt, d0);
    check("t6_tx_fifo_empty", tx_start_q.size(), t);
    check("t6_txd_idle", txd, 1);
    rst = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    wait_cyc(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
